// File: rtl/alu_normalize.sv
// alu_normalize: iterative CLZ/CLO normalizer for the MIPS32 ALU.
// A binary search over the operand runs one stage per clock, with stages of
// WIDTH/2, WIDTH/4, ... down to 1 bit. It returns the count of leading bits
// that equal the target bit. It also returns the operand left-justified by
// that count.
module alu_normalize #(
  parameter int WIDTH = 32,
  localparam int CW = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] res
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  localparam logic [CW-1:0] KINIT = CW'(WIDTH / 2);
  localparam logic [CW-1:0] KLAST = CW'(1);

  state_t           state, state_next;
  logic [WIDTH-1:0] work, work_step, top_mask, res_next;
  logic [CW-1:0]    acc, acc_step, k, count_next;
  logic             tgt, match, fin, accept, last;

  assign last = (k == KLAST);

  // State register; reset drops any in-flight search without a done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and handshake decode; DONE accepts a new start for back-to-back use
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SEARCH;
        end
      end
      SEARCH: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = SEARCH;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One search stage: shift out the top k bits when all of them match the target.
  // The final +1 fixup is also computed here, so the results can be loaded
  // at the edge that enters DONE.
  always_comb begin
    top_mask  = ~({WIDTH{1'b1}} >> k);
    match     = (((work ^ {WIDTH{tgt}}) & top_mask) == '0);
    work_step = work;
    acc_step  = acc;
    if (match) begin
      work_step = work << k;
      acc_step  = acc + k;
    end
    fin        = (work_step[WIDTH-1] == tgt);
    count_next = acc_step + {{(CW-1){1'b0}}, fin};
    res_next   = fin ? (work_step << 1) : work_step;
  end

  // Datapath registers; count/res hold until the last stage of the next search
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work  <= '0;
      tgt   <= 1'b0;
      acc   <= '0;
      k     <= '0;
      count <= '0;
      res   <= '0;
    end else if (accept) begin
      work <= a;
      tgt  <= mode;
      acc  <= '0;
      k    <= KINIT;
    end else if (state == SEARCH) begin
      work <= work_step;
      acc  <= acc_step;
      k    <= k >> 1;
      if (last) begin
        count <= count_next;
        res   <= res_next;
      end
    end
  end

endmodule

// File: tb/tb_alu_normalize.sv
// tb_alu_normalize: directed and reference-model checks of the CLZ/CLO normalizer.
module tb_alu_normalize;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic [31:0] a;
  logic        busy;
  logic        done;
  logic [5:0]  count;
  logic [31:0] res;

  int nCompared;
  int nMismatched;

  alu_normalize #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .a     (a),
    .busy  (busy),
    .done  (done),
    .count (count),
    .res   (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Starts one operation. The caller must be at a negedge. The task returns
  // at the negedge inside the done cycle, or when the cycle budget runs out.
  task automatic applyStimulus(input logic m, input logic [31:0] v, input bit pulseBusy,
                               output int lat, output int busyCycles, output bit gotDone);
    start = 1'b1;
    mode  = m;
    a     = v;
    lat = 0;
    busyCycles = 0;
    gotDone = 1'b0;
    while (lat < 20 && !gotDone) begin
      @(negedge clk);
      lat++;
      start = pulseBusy && (lat == 2);
      a     = ~v;
      mode  = ~m;
      if (busy) busyCycles++;
      if (done) gotDone = 1'b1;
    end
  endtask

  // Checks count and res, and rebuilds the operand from them.
  task automatic checkOp(input string tag, input logic m, input logic [31:0] v,
                         input logic [5:0] expCount, input logic [31:0] expRes);
    logic [31:0] recon;
    checkOutput({tag, "_count"}, 64'(count), 64'(expCount));
    checkOutput({tag, "_res"}, 64'(res), 64'(expRes));
    if (count < 6'd32) begin
      recon = (res >> count) | (m ? ~(32'hFFFF_FFFF >> count) : 32'h0);
      checkOutput({tag, "_invariant"}, 64'(recon), 64'(v));
    end
  endtask

  function automatic logic [5:0] refCount(input logic m, input logic [31:0] v);
    int n;
    bit stop;
    n = 0;
    stop = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!stop && v[i] == m) n++;
      else stop = 1'b1;
    end
    return 6'(n);
  endfunction

  typedef struct {
    logic        m;
    logic [31:0] v;
    logic [5:0]  c;
    logic [31:0] r;
  } vec_t;

  initial begin
    int lat, busyCycles, extraDone;
    bit gotDone;
    vec_t vecs[8];
    logic        rm;
    logic [31:0] rv;
    logic [5:0]  rc;
    logic [31:0] rr;

    nCompared   = 0;
    nMismatched = 0;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    a     = 32'h0;

    vecs[0] = '{1'b0, 32'h0000_0001, 6'd31, 32'h8000_0000};
    vecs[1] = '{1'b0, 32'h0000_0000, 6'd32, 32'h0000_0000};
    vecs[2] = '{1'b1, 32'hFFFF_FFFF, 6'd32, 32'h0000_0000};
    vecs[3] = '{1'b1, 32'hFFF0_1234, 6'd12, 32'h0123_4000};
    vecs[4] = '{1'b1, 32'h7FFF_FFFF, 6'd0,  32'h7FFF_FFFF};
    vecs[5] = '{1'b0, 32'h8000_0000, 6'd0,  32'h8000_0000};
    vecs[6] = '{1'b1, 32'hFFFF_FFFE, 6'd31, 32'h0000_0000};
    vecs[7] = '{1'b0, 32'h00FF_0000, 6'd8,  32'hFF00_0000};

    #12;
    checkOutput("reset_busy",  64'(busy),  64'(0));
    checkOutput("reset_done",  64'(done),  64'(0));
    checkOutput("reset_count", 64'(count), 64'(0));
    checkOutput("reset_res",   64'(res),   64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].m, vecs[i].v, 1'b0, lat, busyCycles, gotDone);
      checkOutput($sformatf("vec%0d_done", i), 64'(gotDone), 64'(1));
      checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'(6));
      checkOutput($sformatf("vec%0d_busy_cycles", i), 64'(busyCycles), 64'(5));
      checkOp($sformatf("vec%0d", i), vecs[i].m, vecs[i].v, vecs[i].c, vecs[i].r);
      @(negedge clk);
    end

    $display("[TB] back-to-back with ignored start while busy");
    applyStimulus(1'b0, 32'h0001_8000, 1'b0, lat, busyCycles, gotDone);
    checkOutput("b2b1_done", 64'(gotDone), 64'(1));
    checkOp("b2b1", 1'b0, 32'h0001_8000, 6'd15, 32'hC000_0000);
    applyStimulus(1'b0, 32'h8000_0000, 1'b1, lat, busyCycles, gotDone);
    checkOutput("b2b2_done", 64'(gotDone), 64'(1));
    checkOutput("b2b2_latency", 64'(lat), 64'(6));
    checkOutput("b2b2_busy_cycles", 64'(busyCycles), 64'(5));
    checkOp("b2b2", 1'b0, 32'h8000_0000, 6'd0, 32'h8000_0000);
    start = 1'b0;
    extraDone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) extraDone++;
    end
    checkOutput("no_extra_done", 64'(extraDone), 64'(0));
    checkOutput("hold_count", 64'(count), 64'(0));
    checkOutput("hold_res", 64'(res), 64'(32'h8000_0000));

    $display("[TB] reset during search");
    applyStimulus(1'b1, 32'hFFF0_1234, 1'b0, lat, busyCycles, gotDone);
    checkOp("pre_reset", 1'b1, 32'hFFF0_1234, 6'd12, 32'h0123_4000);
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b0;
    a     = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    checkOutput("busy_before_reset", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy",  64'(busy),  64'(0));
    checkOutput("midreset_done",  64'(done),  64'(0));
    checkOutput("midreset_count", 64'(count), 64'(0));
    checkOutput("midreset_res",   64'(res),   64'(0));
    extraDone = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) extraDone++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) extraDone++;
    end
    checkOutput("reset_no_done", 64'(extraDone), 64'(0));
    applyStimulus(1'b0, 32'h0000_00FF, 1'b0, lat, busyCycles, gotDone);
    checkOutput("post_reset_done", 64'(gotDone), 64'(1));
    checkOutput("post_reset_latency", 64'(lat), 64'(6));
    checkOp("post_reset", 1'b0, 32'h0000_00FF, 6'd24, 32'hFF00_0000);
    @(negedge clk);

    $display("[TB] random operands against reference model");
    for (int i = 0; i < 1000; i++) begin
      rm = 1'($urandom_range(0, 1));
      case (i % 50)
        0:       rv = 32'h0000_0000;
        1:       rv = 32'hFFFF_FFFF;
        default: rv = $urandom() >> $urandom_range(0, 31);
      endcase
      if (rm && (i % 2 == 0)) rv = ~rv;
      rc = refCount(rm, rv);
      rr = (rc == 6'd32) ? 32'h0 : (rv << rc);
      applyStimulus(rm, rv, 1'b0, lat, busyCycles, gotDone);
      checkOutput("rand_done", 64'(gotDone), 64'(1));
      checkOp($sformatf("rand%0d", i), rm, rv, rc, rr);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
